// File: rtl/md_pkg.sv
// Shared encodings and defaults for the HI/LO multiply-divide unit.
package md_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIV  = 2'd2
    } md_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W           = 8;

    function automatic logic md_op_valid(input md_op_e op);
        return (op != MD_NONE) && (op != MD_RSVD);
    endfunction

endpackage

// File: rtl/md_if.sv
// E-stage request / status bundle between the pipeline and the MD controller.
interface md_if;
    logic        md_start;
    logic [2:0]  md_op;
    logic        md_cancel;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        d_is_md;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output md_start, md_op, md_cancel, src_a, src_b, d_is_md,
        input  busy, md_stall, hi, lo
    );

    modport slave (
        input  md_start, md_op, md_cancel, src_a, src_b, d_is_md,
        output busy, md_stall, hi, lo
    );
endinterface

// File: rtl/md_arith.sv
// Purpose: combinational 64-bit product and 32/32 quotient/remainder with div-by-zero flag.
// Latency: zero (pure combinational).
// Backpressure: none; results are sampled by md_controller only on accept.
module md_arith
    import md_pkg::*;
(
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [2:0]  md_op,
    output logic [63:0] prod,
    output logic [31:0] quot,
    output logic [31:0] rem,
    output logic        div_zero
);

    md_op_e      op;
    logic        is_signed;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] safe_b;
    logic [31:0] uq;
    logic [31:0] ur;

    assign op        = md_op_e'(md_op);
    assign is_signed = (op == MD_MULT) || (op == MD_DIV);

    always_comb begin
        ext_a = is_signed ? {{32{src_a[31]}}, src_a} : {32'd0, src_a};
        ext_b = is_signed ? {{32{src_b[31]}}, src_b} : {32'd0, src_b};
        // Low 64 bits of the extended product are correct for both signednesses.
        prod  = ext_a * ext_b;

        // Sign-magnitude division: truncation toward zero falls out naturally, and
        // 0x80000000 / -1 yields magnitude 0x80000000 with no negation.
        neg_a    = is_signed & src_a[31];
        neg_b    = is_signed & src_b[31];
        mag_a    = neg_a ? (32'd0 - src_a) : src_a;
        mag_b    = neg_b ? (32'd0 - src_b) : src_b;
        div_zero = (src_b == 32'd0);
        safe_b   = div_zero ? 32'd1 : mag_b;
        uq       = mag_a / safe_b;
        ur       = mag_a % safe_b;
        quot     = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
        rem      = neg_a ? (32'd0 - ur) : ur;
    end

endmodule

// File: rtl/md_controller.sv
// Purpose: sequences mult/div/mthi/mtlo into architectural HI/LO, modelling multi-cycle latency.
// Latency: mult MULT_CYCLES, div DIV_CYCLES busy cycles; mthi/mtlo visible one cycle after accept.
// Backpressure: md_stall holds MD-class instructions in D while busy or accepting; md_start outside IDLE is ignored.
module md_controller
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset_n,
    md_if.slave  md
);

    md_state_e         state_q;
    md_state_e         state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [63:0]       pend_q;
    logic              pend_dz_q;
    logic [31:0]       hi_q;
    logic [31:0]       lo_q;

    md_op_e            op;
    logic              accept;
    logic              is_mul;
    logic              is_div;

    logic [63:0]       prod;
    logic [31:0]       quot;
    logic [31:0]       rem;
    logic              div_zero;

    md_arith u_arith (
        .src_a    (md.src_a),
        .src_b    (md.src_b),
        .md_op    (md.md_op),
        .prod     (prod),
        .quot     (quot),
        .rem      (rem),
        .div_zero (div_zero)
    );

    assign op     = md_op_e'(md.md_op);
    assign accept = md.md_start & ~md.md_cancel & (state_q == ST_IDLE) & md_op_valid(op);
    assign is_mul = (op == MD_MULT) || (op == MD_MULTU);
    assign is_div = (op == MD_DIV)  || (op == MD_DIVU);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && is_mul)      state_d = ST_MULT;
                else if (accept && is_div) state_d = ST_DIV;
            end
            ST_MULT, ST_DIV: begin
                if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            pend_q    <= '0;
            pend_dz_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else if (accept) begin
            if (is_mul) begin
                pend_q    <= prod;
                pend_dz_q <= 1'b0;
                cnt_q     <= CNT_W'(MULT_CYCLES);
            end else if (is_div) begin
                pend_q    <= {rem, quot};
                pend_dz_q <= div_zero;
                cnt_q     <= CNT_W'(DIV_CYCLES);
            end else if (op == MD_MTHI) begin
                hi_q <= md.src_a;
            end else begin
                lo_q <= md.src_a;
            end
        end else if (state_q != ST_IDLE) begin
            if (cnt_q == CNT_W'(1)) begin
                cnt_q <= '0;
                if (!pend_dz_q) begin
                    hi_q <= pend_q[63:32];
                    lo_q <= pend_q[31:0];
                end
            end else begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    assign md.busy     = (state_q != ST_IDLE);
    assign md.md_stall = md.d_is_md & (md.busy | accept);
    assign md.hi       = hi_q;
    assign md.lo       = lo_q;

endmodule

// File: tb/tb_md_controller.sv
// Directed self-checking bench for md_controller.
module tb_md_controller;
    import md_pkg::*;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;

    md_if mdi ();

    md_controller #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .md      (mdi.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one op and returns how many cycles busy stayed high afterwards (bounded).
    task automatic run_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                          output int cyc);
        mdi.md_start = 1'b1;
        mdi.md_op    = op;
        mdi.src_a    = a;
        mdi.src_b    = b;
        tick();
        mdi.md_start = 1'b0;
        mdi.md_op    = MD_NONE;
        cyc = 0;
        while (mdi.busy && cyc < 50) begin
            cyc++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #23;
        n_checks++; if (mdi.busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy got %0b want 0", mdi.busy); end
        n_checks++; if (mdi.hi !== 32'd0)      begin n_fail++; $display("FAIL reset_hi got %h want 0", mdi.hi); end
        n_checks++; if (mdi.lo !== 32'd0)      begin n_fail++; $display("FAIL reset_lo got %h want 0", mdi.lo); end
        n_checks++; if (mdi.md_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %0b want 0", mdi.md_stall); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_mult();
        int cyc;
        run_op(MD_MULT, 32'hFFFF_FFFF, 32'd2, cyc);
        n_checks++; if (cyc !== 5)                begin n_fail++; $display("FAIL mult_cycles got %0d want 5", cyc); end
        n_checks++; if (mdi.hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi got %h want ffffffff", mdi.hi); end
        n_checks++; if (mdi.lo !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mult_lo got %h want fffffffe", mdi.lo); end
    endtask

    task automatic test_multu();
        int cyc;
        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2, cyc);
        n_checks++; if (cyc !== 5)                begin n_fail++; $display("FAIL multu_cycles got %0d want 5", cyc); end
        n_checks++; if (mdi.hi !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_hi got %h want 00000001", mdi.hi); end
        n_checks++; if (mdi.lo !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_lo got %h want fffffffe", mdi.lo); end
    endtask

    task automatic test_div();
        int cyc;
        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, cyc);
        n_checks++; if (cyc !== 10)               begin n_fail++; $display("FAIL div_cycles got %0d want 10", cyc); end
        n_checks++; if (mdi.lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_lo got %h want fffffffd", mdi.lo); end
        n_checks++; if (mdi.hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_hi got %h want ffffffff", mdi.hi); end
    endtask

    task automatic test_div_overflow();
        int cyc;
        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
        n_checks++; if (mdi.lo !== 32'h8000_0000) begin n_fail++; $display("FAIL divovf_lo got %h want 80000000", mdi.lo); end
        n_checks++; if (mdi.hi !== 32'h0000_0000) begin n_fail++; $display("FAIL divovf_hi got %h want 00000000", mdi.hi); end
        run_op(MD_DIVU, 32'd100, 32'd7, cyc);
        n_checks++; if (mdi.lo !== 32'd14)        begin n_fail++; $display("FAIL divu_lo got %h want 0000000e", mdi.lo); end
        n_checks++; if (mdi.hi !== 32'd2)         begin n_fail++; $display("FAIL divu_hi got %h want 00000002", mdi.hi); end
    endtask

    task automatic test_divu_zero();
        int cyc;
        run_op(MD_MTHI, 32'h12, 32'h0, cyc);
        n_checks++; if (cyc !== 0)         begin n_fail++; $display("FAIL mthi_busy got %0d want 0", cyc); end
        n_checks++; if (mdi.hi !== 32'h12) begin n_fail++; $display("FAIL mthi_hi got %h want 00000012", mdi.hi); end
        run_op(MD_MTLO, 32'h34, 32'h0, cyc);
        n_checks++; if (mdi.lo !== 32'h34) begin n_fail++; $display("FAIL mtlo_lo got %h want 00000034", mdi.lo); end
        run_op(MD_DIVU, 32'h55, 32'h0, cyc);
        n_checks++; if (cyc !== 10)        begin n_fail++; $display("FAIL divz_cycles got %0d want 10", cyc); end
        n_checks++; if (mdi.hi !== 32'h12) begin n_fail++; $display("FAIL divz_hi got %h want 00000012", mdi.hi); end
        n_checks++; if (mdi.lo !== 32'h34) begin n_fail++; $display("FAIL divz_lo got %h want 00000034", mdi.lo); end
    endtask

    task automatic test_cancel();
        mdi.d_is_md   = 1'b1;
        mdi.md_start  = 1'b1;
        mdi.md_cancel = 1'b1;
        mdi.md_op     = MD_MULT;
        mdi.src_a     = 32'd3;
        mdi.src_b     = 32'd3;
        #1;
        n_checks++; if (mdi.md_stall !== 1'b0) begin n_fail++; $display("FAIL cancel_stall got %0b want 0", mdi.md_stall); end
        tick();
        mdi.md_start  = 1'b0;
        mdi.md_cancel = 1'b0;
        mdi.d_is_md   = 1'b0;
        n_checks++; if (mdi.busy !== 1'b0) begin n_fail++; $display("FAIL cancel_busy got %0b want 0", mdi.busy); end
        tick();
        tick();
        n_checks++; if (mdi.hi !== 32'h12 || mdi.lo !== 32'h34) begin
            n_fail++; $display("FAIL cancel_hilo got %h/%h want 00000012/00000034", mdi.hi, mdi.lo);
        end
    endtask

    task automatic test_stall();
        int stall_bad;
        int cyc;
        stall_bad = 0;
        cyc = 0;
        mdi.d_is_md  = 1'b1;
        #1;
        n_checks++; if (mdi.md_stall !== 1'b0) begin n_fail++; $display("FAIL idle_stall got %0b want 0", mdi.md_stall); end
        mdi.md_start = 1'b1;
        mdi.md_op    = MD_DIV;
        mdi.src_a    = 32'd100;
        mdi.src_b    = 32'd7;
        #1;
        n_checks++; if (mdi.md_stall !== 1'b1) begin n_fail++; $display("FAIL accept_stall got %0b want 1", mdi.md_stall); end
        tick();
        // A stray mult mid-divide must neither start nor disturb the pending quotient.
        mdi.md_op = MD_MULT;
        mdi.src_a = 32'd9;
        mdi.src_b = 32'd9;
        while (mdi.busy && cyc < 50) begin
            if (mdi.md_stall !== 1'b1) stall_bad++;
            cyc++;
            tick();
            mdi.md_start = 1'b0;
        end
        n_checks++; if (cyc !== 10)            begin n_fail++; $display("FAIL stall_cycles got %0d want 10", cyc); end
        n_checks++; if (stall_bad !== 0)       begin n_fail++; $display("FAIL busy_stall got %0d low cycles want 0", stall_bad); end
        n_checks++; if (mdi.md_stall !== 1'b0) begin n_fail++; $display("FAIL done_stall got %0b want 0", mdi.md_stall); end
        n_checks++; if (mdi.lo !== 32'd14 || mdi.hi !== 32'd2) begin
            n_fail++; $display("FAIL ignored_start got %h/%h want 00000002/0000000e", mdi.hi, mdi.lo);
        end
        mdi.d_is_md = 1'b0;
        mdi.md_op   = MD_NONE;
    endtask

    task automatic test_back_to_back();
        int cyc;
        run_op(MD_MULT, 32'hFFFF_FFFD, 32'd4, cyc);
        n_checks++; if (mdi.hi !== 32'hFFFF_FFFF || mdi.lo !== 32'hFFFF_FFF4) begin
            n_fail++; $display("FAIL b2b_mult got %h/%h want ffffffff/fffffff4", mdi.hi, mdi.lo);
        end
        run_op(MD_MULTU, 32'h0001_0000, 32'h0001_0000, cyc);
        n_checks++; if (cyc !== 5) begin n_fail++; $display("FAIL b2b_cycles got %0d want 5", cyc); end
        n_checks++; if (mdi.hi !== 32'd1 || mdi.lo !== 32'd0) begin
            n_fail++; $display("FAIL b2b_multu got %h/%h want 00000001/00000000", mdi.hi, mdi.lo);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        mdi.md_start = 1'b1;
        mdi.md_op    = MD_DIV;
        mdi.src_a    = 32'd50;
        mdi.src_b    = 32'd3;
        tick();
        mdi.md_start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        reset_n = 1'b0;
        #1;
        n_checks++; if (mdi.busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %0b want 0", mdi.busy); end
        n_checks++; if (mdi.hi !== 32'd0 || mdi.lo !== 32'd0) begin
            n_fail++; $display("FAIL rst_mid_hilo got %h/%h want 0/0", mdi.hi, mdi.lo);
        end
        #3;
        reset_n = 1'b1;
        tick();
        run_op(MD_MTLO, 32'h0000_ABCD, 32'd0, cyc);
        n_checks++; if (mdi.lo !== 32'h0000_ABCD) begin n_fail++; $display("FAIL rst_mtlo got %h want 0000abcd", mdi.lo); end
        n_checks++; if (mdi.hi !== 32'd0 || cyc !== 0) begin
            n_fail++; $display("FAIL rst_after got hi %h busy %0d want 0/0", mdi.hi, cyc);
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        mdi.md_start  = 1'b0;
        mdi.md_op     = MD_NONE;
        mdi.md_cancel = 1'b0;
        mdi.src_a     = '0;
        mdi.src_b     = '0;
        mdi.d_is_md   = 1'b0;
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_div_overflow();
        test_divu_zero();
        test_cancel();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
